// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable bit period, data width, parity and stop bits,
// valid/ready delivery with per-word error flags. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic                 busy
);

    localparam int BCW = $clog2(CLKS_PER_BIT + 1);

`ifdef UART_RX_MAJORITY_EN
    // Decision sits one cycle after the vote centre; reloading to 1 keeps the bit period at CLKS_PER_BIT.
    localparam int BIT_END_I   = CLKS_PER_BIT;
    localparam int START_CHK_I = (CLKS_PER_BIT - 1) / 2 + 1;
    localparam int RELOAD_I    = 1;
`else
    localparam int BIT_END_I   = CLKS_PER_BIT - 1;
    localparam int START_CHK_I = (CLKS_PER_BIT - 1) / 2;
    localparam int RELOAD_I    = 0;
`endif

    localparam logic [BCW-1:0] BIT_END   = BCW'(BIT_END_I);
    localparam logic [BCW-1:0] START_CHK = BCW'(START_CHK_I);
    localparam logic [BCW-1:0] RELOAD    = BCW'(RELOAD_I);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               r_state;
    logic [BCW-1:0]       r_bc;
    logic [3:0]           r_bitcnt;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc;
    logic                 r_ferr;
    logic                 r_perr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;
    logic                 r_busy;

    logic w_sample;
    logic w_bit_done;
    logic w_par_x;
    logic w_ferr_final;
    logic w_can_load;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk) begin
        if (!reset) r_hist <= '1;
        else        r_hist <= {r_hist[0], r_rx_s};
    end

    assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_s) | (r_hist[0] & r_rx_s);
`else
    assign w_sample = r_rx_s;
`endif

    assign w_bit_done   = (r_bc == BIT_END);
    assign w_par_x      = r_par_acc ^ w_sample;
    assign w_ferr_final = r_ferr | ~w_sample;
    assign w_can_load   = ~r_valid | rx_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_bc         <= '0;
            r_bitcnt     <= '0;
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_shift      <= '0;
            r_par_acc    <= 1'b0;
            r_ferr       <= 1'b0;
            r_perr       <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            if (r_valid && rx_ready) r_valid <= 1'b0;
            if (clr_overrun)         r_overrun <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_bc     <= '0;
                    r_bitcnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_bc == START_CHK) begin
                        r_bitcnt <= '0;
                        if (!w_sample) begin
                            r_state   <= S_DATA;
                            r_bc      <= RELOAD;
                            r_par_acc <= 1'b0;
                            r_ferr    <= 1'b0;
                            r_perr    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_bc    <= '0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_bc <= r_bc + BCW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_shift   <= {w_sample, r_shift[DATA_BITS-1:1]};
                        r_par_acc <= w_par_x;
                        r_bc      <= RELOAD;
                        if (r_bitcnt == DATA_LAST) begin
                            r_bitcnt <= '0;
                            r_state  <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end else begin
                        r_bc <= r_bc + BCW'(1);
                    end
                end
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_perr   <= (PARITY == 1) ? ~w_par_x : w_par_x;
                        r_state  <= S_STOP;
                        r_bc     <= RELOAD;
                        r_bitcnt <= '0;
                    end else begin
                        r_bc <= r_bc + BCW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        if (r_bitcnt == STOP_LAST) begin
                            r_state  <= S_IDLE;
                            r_busy   <= 1'b0;
                            r_bc     <= '0;
                            r_bitcnt <= '0;
                            // Holding register free (or being emptied this edge): deliver, else drop and flag.
                            if (w_can_load) begin
                                r_data       <= r_shift;
                                r_valid      <= 1'b1;
                                r_frame_err  <= w_ferr_final;
                                r_parity_err <= r_perr;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_ferr   <= w_ferr_final;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            r_bc     <= RELOAD;
                        end
                    end else begin
                        r_bc <= r_bc + BCW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_bc    <= '0;
                end
            endcase
        end
    end

    assign rx_data       = r_data;
    assign rx_valid      = r_valid;
    assign rx_frame_err  = r_frame_err;
    assign rx_parity_err = r_parity_err;
    assign overrun       = r_overrun;
    assign busy          = r_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 7E1, 8N2) with a short bit period,
// expected words queued per receiver and compared on each valid/ready handshake.
module tb_uart_rx_param;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rx_v;
    logic       rdy_a, rdy_b, rdy_c;
    logic       clr;

    logic [7:0] rd_a;
    logic [6:0] rd_b;
    logic [7:0] rd_c;
    logic       v_a, v_b, v_c;
    logic       fe_a, fe_b, fe_c;
    logic       pe_a, pe_b, pe_c;
    logic       ov_a, ov_b, ov_c;
    logic       busy_a, busy_b, busy_c;

    int checks = 0;
    int errors = 0;
    int vcnt[3];

    typedef struct {
        logic [8:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    typedef struct {
        int         inst;
        logic [8:0] d;
        logic       flip;
        logic [1:0] slow;
        logic [8:0] ed;
        logic       efe;
        logic       epe;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .rx(rx_v[0]), .rx_data(rd_a), .rx_valid(v_a), .rx_ready(rdy_a),
        .rx_frame_err(fe_a), .rx_parity_err(pe_a), .overrun(ov_a), .clr_overrun(clr), .busy(busy_a));

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .reset(reset), .rx(rx_v[1]), .rx_data(rd_b), .rx_valid(v_b), .rx_ready(rdy_b),
        .rx_frame_err(fe_b), .rx_parity_err(pe_b), .overrun(ov_b), .clr_overrun(clr), .busy(busy_b));

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
        .clk(clk), .reset(reset), .rx(rx_v[2]), .rx_data(rd_c), .rx_valid(v_c), .rx_ready(rdy_c),
        .rx_frame_err(fe_c), .rx_parity_err(pe_c), .overrun(ov_c), .clr_overrun(clr), .busy(busy_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int inst);
        case (inst)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_exp(input int inst, input logic [8:0] d, input logic fe, input logic pe);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe;
        case (inst)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic check_word(input int inst, input logic [8:0] d, input logic fe, input logic pe);
        exp_t e;
        checks++;
        if (qsize(inst) == 0) begin
            errors++;
            $display("FAIL word%0d: unexpected word data=0x%0h fe=%0b pe=%0b, none expected", inst, d, fe, pe);
            return;
        end
        case (inst)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        if (d !== e.d || fe !== e.fe || pe !== e.pe) begin
            errors++;
            $display("FAIL word%0d: got data=0x%0h fe=%0b pe=%0b, expected data=0x%0h fe=%0b pe=%0b",
                     inst, d, fe, pe, e.d, e.fe, e.pe);
        end
    endtask

    always @(negedge clk) begin
        if (v_a) vcnt[0]++;
        if (v_b) vcnt[1]++;
        if (v_c) vcnt[2]++;
        if (v_a && rdy_a) check_word(0, {1'b0, rd_a}, fe_a, pe_a);
        if (v_b && rdy_b) check_word(1, {2'b00, rd_b}, fe_b, pe_b);
        if (v_c && rdy_c) check_word(2, {1'b0, rd_c}, fe_c, pe_c);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // par < 0 means no parity bit; glitch_bit inverts one clock at the receiver's sample point.
    task automatic send_frame(input int inst, input logic [8:0] d, input int nbits, input int par,
                              input int nstop, input logic [1:0] slow, input int glitch_bit);
        rx_v[inst] = 1'b0;
        cyc(C);
        for (int i = 0; i < nbits; i++) begin
            rx_v[inst] = d[i];
            if (glitch_bit == i) begin
                cyc(8);
                rx_v[inst] = ~d[i];
                cyc(1);
                rx_v[inst] = d[i];
                cyc(C - 9);
            end else begin
                cyc(C);
            end
        end
        if (par >= 0) begin
            rx_v[inst] = par[0];
            cyc(C);
        end
        for (int s = 0; s < nstop; s++) begin
            rx_v[inst] = ~slow[s];
            cyc(C);
        end
        rx_v[inst] = 1'b1;
    endtask

    task automatic wait_empty(input int inst, input string name);
        logic b;
        for (int k = 0; k < C * 40; k++) begin
            b = (inst == 0) ? busy_a : (inst == 1) ? busy_b : busy_c;
            if (qsize(inst) == 0 && !b) break;
            cyc(1);
        end
        chk(name, qsize(inst), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         nb, ns, par;
        logic [8:0] ge;

        vecs[0] = '{0, 9'h041, 1'b0, 2'b00, 9'h041, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h000, 1'b0, 2'b00, 9'h000, 1'b0, 1'b0};
        vecs[2] = '{0, 9'h0FF, 1'b0, 2'b00, 9'h0FF, 1'b0, 1'b0};
        vecs[3] = '{0, 9'h0A5, 1'b0, 2'b01, 9'h0A5, 1'b1, 1'b0};
        vecs[4] = '{1, 9'h055, 1'b0, 2'b00, 9'h055, 1'b0, 1'b0};
        vecs[5] = '{1, 9'h055, 1'b1, 2'b00, 9'h055, 1'b0, 1'b1};
        vecs[6] = '{1, 9'h02A, 1'b0, 2'b00, 9'h02A, 1'b0, 1'b0};
        vecs[7] = '{2, 9'h0A5, 1'b0, 2'b10, 9'h0A5, 1'b1, 1'b0};
        vecs[8] = '{2, 9'h03C, 1'b0, 2'b00, 9'h03C, 1'b0, 1'b0};
        vecs[9] = '{1, 9'h07F, 1'b1, 2'b01, 9'h07F, 1'b1, 1'b1};

        reset = 1'b0;
        rx_v  = '1;
        rdy_a = 1'b1; rdy_b = 1'b1; rdy_c = 1'b1;
        clr   = 1'b0;
        cyc(5);
        chk("rst_data", rd_a, 0);
        chk("rst_valid", v_a, 0);
        chk("rst_ferr", fe_a, 0);
        chk("rst_perr", pe_a, 0);
        chk("rst_ovr", ov_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_valid_b", v_b, 0);
        chk("rst_busy_c", busy_c, 0);
        reset = 1'b1;
        cyc(2 * C);

        for (int i = 0; i < 10; i++) begin
            nb  = (vecs[i].inst == 1) ? 7 : 8;
            ns  = (vecs[i].inst == 2) ? 2 : 1;
            par = (vecs[i].inst == 1) ? int'((^vecs[i].d[6:0]) ^ vecs[i].flip) : -1;
            push_exp(vecs[i].inst, vecs[i].ed, vecs[i].efe, vecs[i].epe);
            vcnt[vecs[i].inst] = 0;
            send_frame(vecs[i].inst, vecs[i].d, nb, par, ns, vecs[i].slow, -1);
            wait_empty(vecs[i].inst, $sformatf("vec%0d_drain", i));
            cyc(C);
            chk($sformatf("vec%0d_valid_cycles", i), vcnt[vecs[i].inst], 1);
        end

        // Overrun: hold the consumer off across two back-to-back frames.
        rdy_a = 1'b0;
        send_frame(0, 9'h041, 8, -1, 1, 2'b00, -1);
        send_frame(0, 9'h042, 8, -1, 1, 2'b00, -1);
        cyc(C);
        chk("ovr_hold_data", rd_a, 32'h41);
        chk("ovr_hold_valid", v_a, 1);
        chk("ovr_flag", ov_a, 1);
        push_exp(0, 9'h041, 1'b0, 1'b0);
        rdy_a = 1'b1;
        clr   = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(1);
        chk("ovr_cleared", ov_a, 0);
        chk("ovr_valid_drop", v_a, 0);
        chk("ovr_held_popped", qsize(0), 0);
        push_exp(0, 9'h042, 1'b0, 1'b0);
        send_frame(0, 9'h042, 8, -1, 1, 2'b00, -1);
        wait_empty(0, "ovr_new_drain");
        chk("ovr_new_data", rd_a, 32'h42);
        chk("ovr_stays_clear", ov_a, 0);

        // False start: short low pulse shorter than half a bit.
        cyc(C);
        vcnt[0] = 0;
        rx_v[0] = 1'b0;
        cyc(5);
        chk("fs_busy_high", busy_a, 1);
        rx_v[0] = 1'b1;
        cyc(2 * C);
        chk("fs_busy_low", busy_a, 0);
        chk("fs_no_valid", vcnt[0], 0);

        // Reset in the middle of the data bits abandons the frame.
        rx_v[0] = 1'b0; cyc(C);
        rx_v[0] = 1'b1; cyc(C);
        rx_v[0] = 1'b0; cyc(C);
        chk("mid_busy", busy_a, 1);
        reset   = 1'b0;
        rx_v[0] = 1'b1;
        cyc(1);
        chk("mid_rst_data", rd_a, 0);
        chk("mid_rst_valid", v_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_ovr", ov_a, 0);
        reset = 1'b1;
        cyc(2 * C);
        vcnt[0] = 0;
        push_exp(0, 9'h07E, 1'b0, 1'b0);
        send_frame(0, 9'h07E, 8, -1, 1, 2'b00, -1);
        wait_empty(0, "mid_next_drain");
        cyc(C);
        chk("mid_next_count", vcnt[0], 1);

        // One-clock glitch at the sample point of data bit 2.
`ifdef UART_RX_MAJORITY_EN
        ge = 9'h00F;
`else
        ge = 9'h00B;
`endif
        push_exp(0, ge, 1'b0, 1'b0);
        send_frame(0, 9'h00F, 8, -1, 1, 2'b00, 2);
        wait_empty(0, "glitch_drain");
        cyc(C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
